sparhixcel_out_accum: RTL and testbench

Parametrised output stage that replaces the manually steered per-filter mux/BRAM chain behind the systolic array. It accepts one N_COLS_ARRAY-lane result vector per output pixel, accumulates it across channel rounds in local storage, and then drains the tile autonomously. Draining runs one filter value per beat over a valid/ready stream, after arithmetic shift, optional ReLU and saturation. It sits between `systolic_array.result_o` and the host/DMA read path.

---
 rtl/sparhixcel_pkg.sv | 39 +++
 rtl/sparhixcel_out_accum_if.sv | 32 +++
 rtl/sparhixcel_out_accum_postproc.sv | 35 +++
 rtl/sparhixcel_out_accum.sv | 198 +++++++++++++++++++
 tb/tb_sparhixcel_out_accum.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sparhixcel_pkg.sv
// Shared definitions for the sparhixcel output path.
// Contents: FSM state enum, default width constants, and the lane slice helper.
package sparhixcel_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_DRAIN,
      ST_DONE
   } state_e;

   localparam int unsigned DEF_N_COLS_ARRAY        = 16;
   localparam int unsigned DEF_IN_WIDTH            = 16;
   localparam int unsigned DEF_ACC_WIDTH           = 24;
   localparam int unsigned DEF_OUT_WIDTH           = 16;
   localparam int unsigned DEF_DEPTH               = 64;
   localparam int unsigned DEF_COUNTER_ROUND_WIDTH = 3;

   localparam int unsigned SLICE_VEC_W  = 4096;
   localparam int unsigned SLICE_LANE_W = 64;

   // Extract lane 'lane' of 'width' bits from a packed lane vector and sign-extend
   // it to SLICE_LANE_W. lane/width are constants at every call site, so the loop
   // reduces to plain wiring.
   function automatic logic [SLICE_LANE_W-1:0] lane_slice(
      input logic [SLICE_VEC_W-1:0] vec,
      input int unsigned            lane,
      input int unsigned            width
   );
      logic [SLICE_LANE_W-1:0] r;
      r = '0;
      for (int unsigned b = 0; b < SLICE_LANE_W; b++) begin
         if (b < width) r[6'(b)] = vec[12'(lane * width + b)];
         else           r[6'(b)] = r[6'(width - 1)];
      end
      return r;
   endfunction

endpackage

// File: rtl/sparhixcel_out_accum_if.sv
// Stream bundle of the output accumulator.
// in_*  : lane vector input (valid/ready), one pixel per beat.
// out_* : drained single-value output (valid/ready) with filter/pixel tags and last.
// Modports: master = producer/consumer side, slave = accumulator side.
interface sparhixcel_out_accum_if
   import sparhixcel_pkg::*;
#(
   parameter int unsigned N_COLS_ARRAY = DEF_N_COLS_ARRAY,
   parameter int unsigned IN_WIDTH     = DEF_IN_WIDTH,
   parameter int unsigned OUT_WIDTH    = DEF_OUT_WIDTH,
   parameter int unsigned DEPTH        = DEF_DEPTH
);
   logic                             in_valid;
   logic                             in_ready;
   logic [N_COLS_ARRAY*IN_WIDTH-1:0] in_data;
   logic                             out_valid;
   logic                             out_ready;
   logic [OUT_WIDTH-1:0]             out_data;
   logic [$clog2(N_COLS_ARRAY)-1:0]  out_filter;
   logic [$clog2(DEPTH)-1:0]         out_pixel;
   logic                             out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_filter, out_pixel, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_filter, out_pixel, out_last
   );
endinterface

// File: rtl/sparhixcel_out_accum_postproc.sv
// out_postproc: combinational post-processing of one accumulator value.
// value  : signed accumulator value
// shift  : arithmetic right shift amount
// relu   : clamp negative results to zero
// result : shifted/ReLU'd value saturated to signed OUT_WIDTH
module out_postproc
   import sparhixcel_pkg::*;
#(
   parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
   parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH
) (
   input  logic signed [ACC_WIDTH-1:0]         value,
   input  logic        [$clog2(ACC_WIDTH)-1:0] shift,
   input  logic                                relu,
   output logic        [OUT_WIDTH-1:0]         result
);
   localparam int unsigned W = (ACC_WIDTH > OUT_WIDTH) ? ACC_WIDTH : OUT_WIDTH;

   logic signed [ACC_WIDTH-1:0] shifted;
   logic signed [W-1:0]         wide;
   logic signed [W-1:0]         max_w;
   logic signed [W-1:0]         min_w;

   always_comb begin
      shifted = value >>> shift;
      wide    = W'(shifted);
      if (relu && (wide < 0)) wide = '0;
      max_w = '0;
      max_w[OUT_WIDTH-2:0] = '1;
      min_w = ~max_w;
      if (wide > max_w)      result = max_w[OUT_WIDTH-1:0];
      else if (wide < min_w) result = min_w[OUT_WIDTH-1:0];
      else                   result = wide[OUT_WIDTH-1:0];
   end
endmodule

// File: rtl/sparhixcel_out_accum.sv
// sparhixcel_out_accum: accumulates N_COLS_ARRAY-lane result vectors per pixel
// across channel rounds, then drains the tile one filter value per beat.
// Ports: clk_i, general_rst_ni (async, active-low), start_i + cfg_* (tile setup,
// latched on an accepted start), stream (in/out valid-ready bundle, slave side),
// busy_o (not idle), done_o (one-cycle end-of-tile pulse), overflow_o (sticky
// accumulator saturation, cleared by an accepted start).
module sparhixcel_out_accum
   import sparhixcel_pkg::*;
#(
   parameter int unsigned N_COLS_ARRAY        = DEF_N_COLS_ARRAY,
   parameter int unsigned IN_WIDTH            = DEF_IN_WIDTH,
   parameter int unsigned ACC_WIDTH           = DEF_ACC_WIDTH,
   parameter int unsigned OUT_WIDTH           = DEF_OUT_WIDTH,
   parameter int unsigned DEPTH               = DEF_DEPTH,
   parameter int unsigned COUNTER_ROUND_WIDTH = DEF_COUNTER_ROUND_WIDTH
) (
   input  logic                                   clk_i,
   input  logic                                   general_rst_ni,
   input  logic                                   start_i,
   input  logic [$clog2(DEPTH+1)-1:0]             cfg_n_pixels_i,
   input  logic [COUNTER_ROUND_WIDTH-1:0]         cfg_n_rounds_i,
   input  logic [$clog2(N_COLS_ARRAY+1)-1:0]      cfg_n_filters_i,
   input  logic                                   cfg_relu_i,
   input  logic [$clog2(ACC_WIDTH)-1:0]           cfg_shift_i,
   sparhixcel_out_accum_if.slave                  stream,
   output logic                                   busy_o,
   output logic                                   done_o,
   output logic                                   overflow_o
);
   localparam int unsigned NPIX_W  = $clog2(DEPTH+1);
   localparam int unsigned PIX_W   = $clog2(DEPTH);
   localparam int unsigned NFIL_W  = $clog2(N_COLS_ARRAY+1);
   localparam int unsigned LANE_W  = $clog2(N_COLS_ARRAY);
   localparam int unsigned SHIFT_W = $clog2(ACC_WIDTH);
   localparam int unsigned RW      = COUNTER_ROUND_WIDTH;

   state_e                  state, state_next;
   logic [NPIX_W-1:0]       n_pixels;
   logic [RW-1:0]           n_rounds, round_cnt;
   logic [NFIL_W-1:0]       n_filters;
   logic                    relu;
   logic [SHIFT_W-1:0]      shift;
   logic [PIX_W-1:0]        pix_cnt, rd_pix, out_pixel;
   logic [LANE_W-1:0]       rd_fil, out_filter;
   logic                    in_ready, accept, last_pix, last_round, cfg_zero;
   logic                    rd_last_fil, rd_last_pix, drain_hs;
   logic                    out_valid, out_last, overflow;
   logic [OUT_WIDTH-1:0]    out_data, pp_result;
   logic [N_COLS_ARRAY-1:0] lane_sat;
   logic [ACC_WIDTH-1:0]    rd_lane [N_COLS_ARRAY];
   logic [ACC_WIDTH-1:0]    rd_val;

   assign accept      = stream.in_valid && (state == ST_ACCUM);
   assign last_pix    = NPIX_W'(pix_cnt) == (n_pixels - NPIX_W'(1));
   assign last_round  = round_cnt == (n_rounds - RW'(1));
   assign rd_last_fil = NFIL_W'(rd_fil) == (n_filters - NFIL_W'(1));
   assign rd_last_pix = NPIX_W'(rd_pix) == (n_pixels - NPIX_W'(1));
   assign cfg_zero    = (cfg_n_pixels_i == '0) || (cfg_n_rounds_i == '0) || (cfg_n_filters_i == '0);
   assign drain_hs    = out_valid && stream.out_ready && out_last;

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      done_o     = 1'b0;
      busy_o     = (state != ST_IDLE);
      unique case (state)
         ST_IDLE:  if (start_i) state_next = cfg_zero ? ST_DONE : ST_ACCUM;
         ST_ACCUM: begin
            in_ready = 1'b1;
            if (accept && last_pix && last_round) state_next = ST_DRAIN;
         end
         ST_DRAIN: if (drain_hs) state_next = ST_DONE;
         ST_DONE: begin
            done_o     = 1'b1;
            state_next = ST_IDLE;
         end
         default:  state_next = ST_IDLE;
      endcase
   end

   // Per-lane storage and accumulate/saturate datapath.
   for (genvar g = 0; g < N_COLS_ARRAY; g++) begin : g_lane
      logic signed [ACC_WIDTH-1:0] lane_mem [DEPTH];
      logic signed [ACC_WIDTH-1:0] ext, old, wr_val;
      logic signed [ACC_WIDTH:0]   sum;
      logic                        sat;

      always_comb begin
         ext    = ACC_WIDTH'(lane_slice(SLICE_VEC_W'(stream.in_data), g, IN_WIDTH));
         old    = lane_mem[pix_cnt];
         sum    = {old[ACC_WIDTH-1], old} + {ext[ACC_WIDTH-1], ext};
         sat    = 1'b0;
         wr_val = ext;
         if (round_cnt != '0) begin
            if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
               sat    = 1'b1;
               wr_val = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end else begin
               wr_val = sum[ACC_WIDTH-1:0];
            end
         end
      end

      always_ff @(posedge clk_i) begin
         if (accept) lane_mem[pix_cnt] <= wr_val;
      end

      assign lane_sat[g] = sat;
      assign rd_lane[g]  = lane_mem[rd_pix];
   end

   assign rd_val = rd_lane[rd_fil];

   out_postproc #(
      .ACC_WIDTH (ACC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_postproc (
      .value  (rd_val),
      .shift  (shift),
      .relu   (relu),
      .result (pp_result)
   );

   always_ff @(posedge clk_i or negedge general_rst_ni) begin
      if (!general_rst_ni) begin
         state      <= ST_IDLE;
         n_pixels   <= '0;
         n_rounds   <= '0;
         n_filters  <= '0;
         relu       <= 1'b0;
         shift      <= '0;
         pix_cnt    <= '0;
         round_cnt  <= '0;
         rd_pix     <= '0;
         rd_fil     <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_data   <= '0;
         out_filter <= '0;
         out_pixel  <= '0;
         overflow   <= 1'b0;
      end else begin
         state <= state_next;
         unique case (state)
            ST_IDLE: if (start_i) begin
               n_pixels  <= cfg_n_pixels_i;
               n_rounds  <= cfg_n_rounds_i;
               n_filters <= cfg_n_filters_i;
               relu      <= cfg_relu_i;
               shift     <= cfg_shift_i;
               pix_cnt   <= '0;
               round_cnt <= '0;
               rd_pix    <= '0;
               rd_fil    <= '0;
               overflow  <= 1'b0;
            end
            ST_ACCUM: if (accept) begin
               if (|lane_sat) overflow <= 1'b1;
               if (last_pix) begin
                  pix_cnt   <= '0;
                  round_cnt <= round_cnt + RW'(1);
               end else begin
                  pix_cnt <= pix_cnt + PIX_W'(1);
               end
            end
            // Output register refills whenever it is empty or being consumed;
            // the read pointer runs one beat ahead of out_*.
            ST_DRAIN: begin
               if (drain_hs) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
               end else if (!out_valid || stream.out_ready) begin
                  out_valid  <= 1'b1;
                  out_data   <= pp_result;
                  out_filter <= rd_fil;
                  out_pixel  <= rd_pix;
                  out_last   <= rd_last_pix && rd_last_fil;
                  if (rd_last_fil) begin
                     rd_fil <= '0;
                     rd_pix <= rd_pix + PIX_W'(1);
                  end else begin
                     rd_fil <= rd_fil + LANE_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign stream.in_ready   = in_ready;
   assign stream.out_valid  = out_valid;
   assign stream.out_data   = out_data;
   assign stream.out_filter = out_filter;
   assign stream.out_pixel  = out_pixel;
   assign stream.out_last   = out_last;
   assign overflow_o        = overflow;
endmodule

// File: tb/tb_sparhixcel_out_accum.sv
// Testbench for sparhixcel_out_accum: default instance (ACC_WIDTH=24) plus a
// narrow instance (ACC_WIDTH=17) for accumulator saturation. Expected beats are
// computed by a small integer model and queued, then popped as the DUT drains.
module tb_sparhixcel_out_accum;

   typedef struct {
      longint data;
      int     fil;
      int     pix;
      bit     last;
   } beat_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start_a = 1'b0, start_b = 1'b0;
   logic         sel = 1'b0;
   logic [6:0]   cfg_n_pixels = '0;
   logic [2:0]   cfg_n_rounds = '0;
   logic [4:0]   cfg_n_filters = '0;
   logic         cfg_relu = 1'b0;
   logic [4:0]   cfg_shift = '0;
   logic         in_valid = 1'b0;
   logic [255:0] in_data = '0;
   logic         out_ready = 1'b1;
   logic         busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;

   int           total = 0;
   int           bad = 0;
   int           stim [3][2][16];
   beat_t        sb [$];

   always #5 clk = ~clk;

   sparhixcel_out_accum_if #(.N_COLS_ARRAY(16), .IN_WIDTH(16), .OUT_WIDTH(16), .DEPTH(64)) bus_a ();
   sparhixcel_out_accum_if #(.N_COLS_ARRAY(16), .IN_WIDTH(16), .OUT_WIDTH(16), .DEPTH(64)) bus_b ();

   assign bus_a.in_valid  = in_valid & ~sel;
   assign bus_b.in_valid  = in_valid & sel;
   assign bus_a.in_data   = in_data;
   assign bus_b.in_data   = in_data;
   assign bus_a.out_ready = out_ready;
   assign bus_b.out_ready = out_ready;

   sparhixcel_out_accum #(
      .N_COLS_ARRAY(16), .IN_WIDTH(16), .ACC_WIDTH(24), .OUT_WIDTH(16), .DEPTH(64), .COUNTER_ROUND_WIDTH(3)
   ) u_dut (
      .clk_i(clk), .general_rst_ni(rst_n), .start_i(start_a),
      .cfg_n_pixels_i(cfg_n_pixels), .cfg_n_rounds_i(cfg_n_rounds), .cfg_n_filters_i(cfg_n_filters),
      .cfg_relu_i(cfg_relu), .cfg_shift_i(cfg_shift), .stream(bus_a),
      .busy_o(busy_a), .done_o(done_a), .overflow_o(ovf_a)
   );

   sparhixcel_out_accum #(
      .N_COLS_ARRAY(16), .IN_WIDTH(16), .ACC_WIDTH(17), .OUT_WIDTH(16), .DEPTH(64), .COUNTER_ROUND_WIDTH(3)
   ) u_ovf (
      .clk_i(clk), .general_rst_ni(rst_n), .start_i(start_b),
      .cfg_n_pixels_i(cfg_n_pixels), .cfg_n_rounds_i(cfg_n_rounds), .cfg_n_filters_i(cfg_n_filters),
      .cfg_relu_i(cfg_relu), .cfg_shift_i(cfg_shift), .stream(bus_b),
      .busy_o(busy_b), .done_o(done_b), .overflow_o(ovf_b)
   );

   logic               m_valid, m_last, m_done, m_busy, m_ovf, m_in_ready;
   logic signed [15:0] m_data;
   logic [3:0]         m_fil;
   logic [5:0]         m_pix;
   assign m_valid    = sel ? bus_b.out_valid  : bus_a.out_valid;
   assign m_last     = sel ? bus_b.out_last   : bus_a.out_last;
   assign m_data     = sel ? bus_b.out_data   : bus_a.out_data;
   assign m_fil      = sel ? bus_b.out_filter : bus_a.out_filter;
   assign m_pix      = sel ? bus_b.out_pixel  : bus_a.out_pixel;
   assign m_in_ready = sel ? bus_b.in_ready   : bus_a.in_ready;
   assign m_done     = sel ? done_b : done_a;
   assign m_busy     = sel ? busy_b : busy_a;
   assign m_ovf      = sel ? ovf_b  : ovf_a;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_stim();
      foreach (stim[r, p, l]) stim[r][p][l] = 0;
   endtask

   function automatic longint clamp(input longint v, input int w);
      longint mx = (longint'(1) <<< (w - 1)) - 1;
      longint mn = -mx - 1;
      if (v > mx) return mx;
      if (v < mn) return mn;
      return v;
   endfunction

   // Reference model: returns expected overflow, pushes expected beats.
   task automatic model(input bit s, input int npix, input int nr, input int nf,
                        input bit rl, input int sh, output bit ovf);
      int aw = s ? 17 : 24;
      ovf = 1'b0;
      for (int p = 0; p < npix; p++) begin
         for (int l = 0; l < 16; l++) begin
            longint acc = 0;
            for (int r = 0; r < nr; r++) begin
               longint nxt = (r == 0) ? longint'(stim[r][p][l]) : acc + stim[r][p][l];
               if (clamp(nxt, aw) != nxt) ovf = 1'b1;
               acc = clamp(nxt, aw);
            end
            if (l < nf) begin
               beat_t b;
               longint v = acc >>> sh;
               if (rl && v < 0) v = 0;
               b.data = clamp(v, 16);
               b.fil  = l;
               b.pix  = p;
               b.last = (p == npix - 1) && (l == nf - 1);
               sb.push_back(b);
            end
         end
      end
   endtask

   task automatic start_tile(input bit s, input int npix, input int nr, input int nf,
                             input bit rl, input int sh);
      @(negedge clk);
      sel = s;
      cfg_n_pixels = 7'(npix);
      cfg_n_rounds = 3'(nr);
      cfg_n_filters = 5'(nf);
      cfg_relu = rl;
      cfg_shift = 5'(sh);
      if (s) start_b = 1'b1; else start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      chk("ovf_cleared_by_start", m_ovf, 0);
   endtask

   task automatic send_tile(input int npix, input int nr);
      for (int r = 0; r < nr; r++) begin
         for (int p = 0; p < npix; p++) begin
            int n = 0;
            for (int l = 0; l < 16; l++) in_data[l*16 +: 16] = 16'(stim[r][p][l]);
            in_valid = 1'b1;
            while (!m_in_ready && n < 20) begin
               @(negedge clk);
               n++;
            end
            if (n >= 20) chk("in_ready_timeout", m_in_ready, 1);
            @(negedge clk);
            in_valid = 1'b0;
         end
      end
   endtask

   task automatic drain(input int stall_after);
      int beats = 0, stall = 0, cyc = 0, first_valid = -1;
      int exp_n = sb.size();
      bit got_last = 1'b0, held = 1'b0;
      logic [15:0] h_data;
      logic [3:0]  h_fil;
      logic [5:0]  h_pix;
      logic        h_last;
      while (!got_last && cyc < 300) begin
         if (stall > 0) begin
            out_ready = 1'b0;
            stall--;
         end else begin
            out_ready = 1'b1;
         end
         if (held) begin
            chk("stall_data", m_data, signed'(h_data));
            chk("stall_filter", m_fil, h_fil);
            chk("stall_pixel", m_pix, h_pix);
            chk("stall_last", m_last, h_last);
         end
         if (m_valid && first_valid < 0) first_valid = cyc;
         held = m_valid && !out_ready;
         h_data = m_data;
         h_fil = m_fil;
         h_pix = m_pix;
         h_last = m_last;
         if (m_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("extra_beat", beats + 1, exp_n);
            end else begin
               beat_t e = sb.pop_front();
               chk("beat_data", m_data, e.data);
               chk("beat_filter", m_fil, e.fil);
               chk("beat_pixel", m_pix, e.pix);
               chk("beat_last", m_last, e.last);
            end
            beats++;
            if (beats == stall_after) stall = 3;
            if (m_last) got_last = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      out_ready = 1'b1;
      chk("drain_completed", got_last, 1);
      chk("first_valid_latency", first_valid, 1);
      chk("beat_count", beats, exp_n);
      chk("done_state_valid", m_valid, 0);
      chk("done_pulse", m_done, 1);
      @(negedge clk);
      chk("done_one_cycle", m_done, 0);
      chk("idle_after_done", m_busy, 0);
      sb.delete();
   endtask

   task automatic run_tile(input bit s, input int npix, input int nr, input int nf,
                           input bit rl, input int sh, input int stall_after);
      bit ovf;
      model(s, npix, nr, nf, rl, sh, ovf);
      start_tile(s, npix, nr, nf, rl, sh);
      send_tile(npix, nr);
      drain(stall_after);
      chk("overflow_flag", m_ovf, ovf);
   endtask

   initial begin
      int pulses, vseen;

      // Reset state
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         chk("rst_in_ready", m_in_ready, 0);
         chk("rst_out_valid", m_valid, 0);
         chk("rst_done", m_done, 0);
         chk("rst_overflow", m_ovf, 0);
         chk("rst_busy", m_busy, 0);
         chk("rst_out_data", m_data, 0);
      end
      sel = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Single round
      clear_stim();
      for (int p = 0; p < 2; p++)
         for (int l = 2; l < 16; l++) stim[0][p][l] = l * 11 - 50 + p;
      stim[0][0][0] = 5;  stim[0][0][1] = -3;
      stim[0][1][0] = 7;  stim[0][1][1] = 100;
      run_tile(0, 2, 1, 2, 0, 0, -1);

      // Accumulation over three rounds
      clear_stim();
      stim[0][0][0] = 10; stim[1][0][0] = 20; stim[2][0][0] = -5;
      run_tile(0, 1, 3, 1, 0, 0, -1);

      // ReLU and shift
      clear_stim();
      stim[0][0][0] = -40; stim[0][0][1] = 1000;
      run_tile(0, 1, 1, 2, 1, 2, -1);

      // Output saturation (stored +/-40000)
      clear_stim();
      stim[0][0][0] = 20000;  stim[1][0][0] = 20000;
      stim[0][0][1] = -20000; stim[1][0][1] = -20000;
      run_tile(0, 1, 2, 2, 0, 0, -1);

      // Backpressure mid-drain
      clear_stim();
      for (int p = 0; p < 2; p++)
         for (int l = 0; l < 16; l++) stim[0][p][l] = p * 100 + l - 7;
      run_tile(0, 2, 1, 3, 0, 0, 2);

      // Accumulator saturation on the narrow instance, then cleared by next start
      clear_stim();
      for (int r = 0; r < 3; r++) stim[r][0][0] = 32767;
      run_tile(1, 1, 3, 1, 0, 0, -1);
      chk("overflow_set", m_ovf, 1);
      clear_stim();
      stim[0][0][0] = 1;
      run_tile(1, 1, 1, 1, 0, 0, -1);

      // Zero configuration
      start_tile(0, 1, 1, 0, 0, 0);
      pulses = 0;
      vseen = 0;
      for (int c = 0; c < 5; c++) begin
         if (m_done) pulses++;
         if (m_valid) vseen++;
         @(negedge clk);
      end
      chk("zero_cfg_done_pulses", pulses, 1);
      chk("zero_cfg_no_valid", vseen, 0);
      chk("zero_cfg_idle", m_busy, 0);

      // Reset mid-drain
      clear_stim();
      stim[0][0][0] = 3; stim[0][1][1] = 4;
      start_tile(0, 2, 1, 2, 0, 0);
      send_tile(2, 1);
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_reset_valid", m_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", m_valid, 0);
      chk("mid_rst_data", m_data, 0);
      chk("mid_rst_filter", m_fil, 0);
      chk("mid_rst_pixel", m_pix, 0);
      chk("mid_rst_last", m_last, 0);
      chk("mid_rst_busy", m_busy, 0);
      chk("mid_rst_done", m_done, 0);
      chk("mid_rst_in_ready", m_in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      pulses = 0;
      for (int c = 0; c < 5; c++) begin
         if (m_done || m_valid) pulses++;
         @(negedge clk);
      end
      chk("no_done_after_reset", pulses, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
